// File: rtl/avl_mem_arbiter.sv
// rtl/avl_mem_arbiter.sv - Avalon-MM read/write arbiter with burst fairness and read throttle
// Optional AVL_ARB_PERF_CNT_EN adds wr_cnt/rd_cnt/stall_cnt performance counters.
module avl_mem_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 29,
    parameter int BURST_MAX   = 16,
    parameter int MAX_RD_PEND = 8,
    parameter int PEND_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ram_rdy,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ack,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    input  logic                  avl_ready,
    output logic                  avl_write_req,
    output logic                  avl_read_req,
    output logic [ADDR_WIDTH-1:0] avl_addr,
    output logic [DATA_WIDTH-1:0] avl_wdata,
    input  logic [DATA_WIDTH-1:0] avl_rdata,
    input  logic                  avl_rdata_valid,
    output logic [PEND_WIDTH-1:0] rd_pend,
`ifdef AVL_ARB_PERF_CNT_EN
    output logic [31:0]           wr_cnt,
    output logic [31:0]           rd_cnt,
    output logic [31:0]           stall_cnt,
`endif
    output logic                  err
);

    typedef enum logic [1:0] {GNT_IDLE, GNT_RD, GNT_WR} gnt_t;

    localparam logic [7:0]          BURST_LIM = BURST_MAX[7:0];
    localparam logic [PEND_WIDTH:0] PEND_LIM  = MAX_RD_PEND[PEND_WIDTH:0];

    gnt_t                state, state_nxt;
    logic [7:0]          burst_cnt, burst_nxt;
    logic                cmd_valid, can_load, rd_ok;
    logic                sel_rd, sel_wr, rd_accept, wr_accept, rd_dec;
    logic [PEND_WIDTH:0] pend_total;

    assign cmd_valid  = avl_write_req | avl_read_req;
    assign can_load   = ram_rdy & (~cmd_valid | avl_ready);
    // A read sitting in the command register is already committed against the limit
    assign pend_total = {1'b0, rd_pend} + {{PEND_WIDTH{1'b0}}, avl_read_req};
    assign rd_ok      = rd_req & (pend_total < PEND_LIM);
    assign rd_accept  = avl_read_req & avl_ready;
    assign wr_accept  = avl_write_req & avl_ready;
    assign rd_dec     = avl_rdata_valid & (rd_pend != '0);
    assign wr_ack     = can_load & sel_wr;
    assign rd_ack     = can_load & sel_rd;

    always_comb begin
        state_nxt = state;
        burst_nxt = burst_cnt;
        sel_rd    = 1'b0;
        sel_wr    = 1'b0;
        case (state)
            GNT_RD: begin
                if (rd_ok && (burst_cnt < BURST_LIM || !wr_req)) sel_rd = 1'b1;
                else if (wr_req)                                 sel_wr = 1'b1;
            end
            GNT_WR: begin
                if (wr_req && (burst_cnt < BURST_LIM || !rd_ok)) sel_wr = 1'b1;
                else if (rd_ok)                                  sel_rd = 1'b1;
            end
            default: begin
                if (rd_ok)       sel_rd = 1'b1;
                else if (wr_req) sel_wr = 1'b1;
            end
        endcase
        if (can_load) begin
            if (sel_rd) begin
                state_nxt = GNT_RD;
                burst_nxt = (state == GNT_RD && burst_cnt < BURST_LIM) ? burst_cnt + 8'd1 : 8'd1;
            end else if (sel_wr) begin
                state_nxt = GNT_WR;
                burst_nxt = (state == GNT_WR && burst_cnt < BURST_LIM) ? burst_cnt + 8'd1 : 8'd1;
            end else begin
                state_nxt = GNT_IDLE;
                burst_nxt = 8'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= GNT_IDLE;
            burst_cnt     <= 8'd0;
            avl_write_req <= 1'b0;
            avl_read_req  <= 1'b0;
            avl_addr      <= '0;
            avl_wdata     <= '0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
            rd_pend       <= '0;
            err           <= 1'b0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            if (can_load && (sel_rd || sel_wr)) begin
                avl_write_req <= sel_wr;
                avl_read_req  <= sel_rd;
                avl_addr      <= sel_wr ? wr_addr : rd_addr;
                if (sel_wr) avl_wdata <= wr_data;
            end else if (avl_ready) begin
                avl_write_req <= 1'b0;
                avl_read_req  <= 1'b0;
            end
            rd_data       <= avl_rdata;
            rd_data_valid <= avl_rdata_valid;
            if (rd_accept && !rd_dec)      rd_pend <= rd_pend + 1'b1;
            else if (!rd_accept && rd_dec) rd_pend <= rd_pend - 1'b1;
            if (avl_rdata_valid && rd_pend == '0) err <= 1'b1;
        end
    end

`ifdef AVL_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            if (wr_accept)               wr_cnt    <= wr_cnt + 32'd1;
            if (rd_accept)               rd_cnt    <= rd_cnt + 32'd1;
            if (cmd_valid && !avl_ready) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = wr_accept;
`endif

endmodule

// File: tb/tb_avl_mem_arbiter.sv
// tb/tb_avl_mem_arbiter.sv - directed table-driven bench for avl_mem_arbiter
module tb_avl_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ram_rdy, wr_req, rd_req, avl_ready, avl_rdata_valid;
    logic [28:0] wr_addr, rd_addr, avl_addr;
    logic [31:0] wr_data, avl_wdata, avl_rdata, rd_data;
    logic        wr_ack, rd_ack, rd_data_valid, avl_write_req, avl_read_req, err;
    logic [7:0]  rd_pend;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avl_mem_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(29), .BURST_MAX(4), .MAX_RD_PEND(8), .PEND_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset), .ram_rdy(ram_rdy),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .avl_ready(avl_ready), .avl_write_req(avl_write_req), .avl_read_req(avl_read_req),
        .avl_addr(avl_addr), .avl_wdata(avl_wdata),
        .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid),
        .rd_pend(rd_pend), .err(err)
    );

    typedef struct {
        logic        wr_req;
        logic [28:0] wr_addr;
        logic [31:0] wr_data;
        logic        exp_wr_ack;
        logic        exp_awr;
        logic [28:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [7:0]  exp_pend;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0;
        avl_rdata = '0; avl_rdata_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
        ram_rdy = 1'b1;
        avl_ready = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_reqs"}, {avl_write_req, avl_read_req, rd_data_valid, err}, 0);
        check({tag, "_addr"}, avl_addr, 0);
        check({tag, "_wdata"}, avl_wdata, 0);
        check({tag, "_rdata"}, rd_data, 0);
        check({tag, "_pend"}, rd_pend, 0);
    endtask

    initial begin
        int   acks;
        logic pat[12];

        vecs[0] = '{1'b1, 29'd2, 32'h102, 1'b1, 1'b0, 29'd0, 32'h0,   8'd0};
        vecs[1] = '{1'b1, 29'd3, 32'h103, 1'b1, 1'b1, 29'd2, 32'h102, 8'd0};
        vecs[2] = '{1'b1, 29'd4, 32'h104, 1'b1, 1'b1, 29'd3, 32'h103, 8'd0};
        vecs[3] = '{1'b1, 29'd5, 32'h105, 1'b1, 1'b1, 29'd4, 32'h104, 8'd0};
        vecs[4] = '{1'b0, 29'd5, 32'h105, 1'b0, 1'b1, 29'd5, 32'h105, 8'd0};
        vecs[5] = '{1'b0, 29'd5, 32'h105, 1'b0, 1'b0, 29'd5, 32'h105, 8'd0};
        pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        reset = 1'b0; ram_rdy = 1'b0; avl_ready = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1 check_all_zero("reset");

        // write stream, one word per cycle
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr_req = vecs[i].wr_req; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
            #1;
            check($sformatf("wr_ack[%0d]", i), wr_ack, vecs[i].exp_wr_ack);
            check($sformatf("rd_ack[%0d]", i), rd_ack, 0);
            check($sformatf("avl_write_req[%0d]", i), avl_write_req, vecs[i].exp_awr);
            check($sformatf("avl_addr[%0d]", i), avl_addr, vecs[i].exp_addr);
            check($sformatf("avl_wdata[%0d]", i), avl_wdata, vecs[i].exp_wdata);
            check($sformatf("rd_pend[%0d]", i), rd_pend, vecs[i].exp_pend);
        end

        // burst fairness with both requesters held
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            wr_req = 1'b1; rd_req = 1'b1; rd_addr = 29'(100 + i); wr_addr = 29'(200 + i);
            #1 check($sformatf("burst_grant[%0d]", i), {rd_ack, wr_ack}, {pat[i], ~pat[i]});
        end
        clear_inputs();

        // outstanding-read throttle
        do_reset();
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rd_req = 1'b1; rd_addr = 29'(i);
            #1 if (rd_ack) acks++;
        end
        check("throttle_acks", acks, 8);
        check("throttle_pend", rd_pend, 8);
        acks = 0;
        @(negedge clk);
        avl_rdata_valid = 1'b1; avl_rdata = 32'h1234_5678;
        #1 if (rd_ack) acks++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            avl_rdata_valid = 1'b0;
            #1 if (rd_ack) acks++;
        end
        check("throttle_release_acks", acks, 1);
        check("throttle_release_pend", rd_pend, 8);
        clear_inputs();

        // avl_ready stall holds the command register
        do_reset();
        @(negedge clk);
        wr_req = 1'b1; wr_addr = 29'd7; wr_data = 32'h11;
        #1 check("stall_first_ack", wr_ack, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            avl_ready = 1'b0; wr_addr = 29'd9; wr_data = 32'hDEAD_BEEF;
            #1;
            check($sformatf("stall_ack[%0d]", i), wr_ack, 0);
            check($sformatf("stall_cmd[%0d]", i), {avl_write_req, avl_read_req, avl_addr}, {2'b10, 29'd7});
            check($sformatf("stall_wdata[%0d]", i), avl_wdata, 32'h11);
        end
        @(negedge clk);
        avl_ready = 1'b1;
        #1 check("stall_release_ack", wr_ack, 1);
        @(negedge clk);
        ram_rdy = 1'b0;
        #1;
        check("stall_new_cmd", {avl_write_req, avl_addr}, {1'b1, 29'd9});
        check("stall_new_wdata", avl_wdata, 32'hDEAD_BEEF);
        check("ram_rdy_low_ack", wr_ack, 0);
        @(negedge clk);
        #1;
        check("ram_rdy_low_drained", avl_write_req, 0);
        check("ram_rdy_low_ack2", wr_ack, 0);
        clear_inputs();
        ram_rdy = 1'b1;

        // read accept coinciding with returned data
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rd_req = 1'b1; rd_addr = 29'(i);
        end
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        rd_req = 1'b1; rd_addr = 29'd3;
        #1;
        check("coinc_pend_before", rd_pend, 3);
        check("coinc_ack", rd_ack, 1);
        @(negedge clk);
        rd_req = 1'b0; avl_rdata_valid = 1'b1; avl_rdata = 32'hA5A5_0003;
        #1 check("coinc_cmd", {avl_read_req, rd_pend}, {1'b1, 8'd3});
        @(negedge clk);
        avl_rdata_valid = 1'b0;
        #1;
        check("coinc_pend_after", rd_pend, 3);
        check("coinc_rdv", {rd_data_valid, rd_data}, {1'b1, 32'hA5A5_0003});
        @(negedge clk);
        #1 check("coinc_rdv_end", rd_data_valid, 0);
        clear_inputs();

        // sticky error, then reset during an outstanding burst
        do_reset();
        @(negedge clk);
        avl_rdata_valid = 1'b1;
        #1 check("err_before", err, 0);
        @(negedge clk);
        avl_rdata_valid = 1'b0;
        #1 check("err_set", {err, rd_pend}, {1'b1, 8'd0});
        repeat (3) @(negedge clk);
        #1 check("err_sticky", err, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd_req = 1'b1; wr_req = 1'b1; rd_addr = 29'(40 + i); wr_addr = 29'(50 + i);
            wr_data = 32'hCAFE_0000 + i;
        end
        @(negedge clk);
        #1 check("midburst_pend_nonzero", rd_pend != 0, 1);
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        #1 check_all_zero("midreset");
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avl_mem_arbiter.md
Name: avl_mem_arbiter

Overview:
- Single-clock arbiter that shares one Avalon-MM port of the external memory interface between a write requester (capture-side frame buffer) and a read requester (display-side frame buffer).
- Owns the Avalon command register, the read/write burst fairness, the outstanding-read throttle and the return-data path.
- Sits between the frame buffer address generators and the memory controller on the Cyclone 5 GX Starter Kit.

Parameters:
- DATA_WIDTH, 32, Avalon data width.
- ADDR_WIDTH, 29, Avalon word address width.
- BURST_MAX, 16, maximum consecutive grants to one requester while the other is requesting; 1..255.
- MAX_RD_PEND, 8, maximum reads issued with data not yet returned; 1..255.
- PEND_WIDTH, 8, width of the pending-read counter; must hold MAX_RD_PEND.

Ports:
- clk  in  1  system/memory clock.
- reset  in  1  synchronous, active-low reset.
- ram_rdy  in  1  memory calibration done; no new commands while low.
- wr_req  in  1  write requester has a word; holds wr_addr/wr_data stable until wr_ack.
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_data  in  DATA_WIDTH  write data.
- wr_ack  out  1  combinational; high for exactly the cycle the write is loaded.
- rd_req  in  1  read requester wants a word; holds rd_addr stable until rd_ack.
- rd_addr  in  ADDR_WIDTH  read word address.
- rd_ack  out  1  combinational; high for exactly the cycle the read is loaded.
- rd_data  out  DATA_WIDTH  registered return data.
- rd_data_valid  out  1  registered, one pulse per returned word.
- avl_ready  in  1  controller accepts the command this cycle.
- avl_write_req  out  1  registered write command.
- avl_read_req  out  1  registered read command.
- avl_addr  out  ADDR_WIDTH  registered command address.
- avl_wdata  out  DATA_WIDTH  registered write data.
- avl_rdata  in  DATA_WIDTH  read data from controller.
- avl_rdata_valid  in  1  read data valid.
- rd_pend  out  PEND_WIDTH  reads accepted by the controller with data not yet returned.
- err  out  1  sticky; set by avl_rdata_valid while rd_pend==0.

Behaviour:
- Reset values: all outputs 0 (avl_write_req, avl_read_req, avl_addr, avl_wdata, rd_data, rd_data_valid, rd_pend, err). Grant state is IDLE and the burst counter is 0.
- Command register: cmd_valid drives avl_write_req/avl_read_req.
  - A command is accepted when (avl_write_req | avl_read_req) & avl_ready at the clock edge.
  - While avl_ready is low, all avl_* outputs hold unchanged.
- Load condition: ram_rdy & (~cmd_valid | avl_ready) & a selected requester. For a read, also (rd_pend + pending read in cmd reg) < MAX_RD_PEND.
- Latency: a req seen at cycle N with the port free gives an ack at N and the avl_*_req output at N+1. Back-to-back loads are possible every cycle while avl_ready stays high.
- Grant FSM states:
  - IDLE: if both requesters request, the read wins. Either single requester is granted. A grant sets the burst counter to 1 and enters RD or WR.
  - RD / WR: the owner keeps the grant while its req is high and burst counter < BURST_MAX; the counter increments per load.
  - Burst limit reached with the other requester requesting: switch owner and set the counter to 1.
  - Burst limit reached with the other requester idle: owner continues and the counter is set to 1.
  - Owner req drops: switch to the other requester if it is requesting, else go to IDLE.
- A read that is throttled by MAX_RD_PEND does not block writes: the write is granted if requesting, following the same switch rules.
- rd_pend:
  - +1 on read acceptance.
  - -1 on avl_rdata_valid.
  - Unchanged when both happen in the same cycle.
  - Never underflows; avl_rdata_valid at 0 sets err.
- Return path: rd_data <= avl_rdata and rd_data_valid <= avl_rdata_valid, one cycle latency, in order.
- ram_rdy low: no loads and no acks. A command already in the register stays until accepted. Return data is still forwarded.
- Reset mid-operation: everything clears. Read data returning afterward is flagged by err; the system must reset the controller together with this block.

Optional Feature:
- Macro: AVL_ARB_PERF_CNT_EN.
- When defined, three extra outputs are added, each a 32-bit counter that is cleared by reset and wraps on overflow:
  - wr_cnt: accepted writes.
  - rd_cnt: accepted reads.
  - stall_cnt: cycles with cmd_valid & ~avl_ready.
- When undefined, these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then ram_rdy=1, avl_ready=1, wr_req held with addr 2..5 -> wr_ack for 4 consecutive cycles; avl_write_req high with avl_addr 2,3,4,5 one cycle later each; rd_pend stays 0.
- BURST_MAX=4, wr_req and rd_req both held continuously -> loads RRRRWWWWRRRR...; first grant is read.
- MAX_RD_PEND=8, rd_req held, no avl_rdata_valid -> exactly 8 rd_ack then none, rd_pend=8. One avl_rdata_valid -> one more rd_ack, rd_pend returns to 8.
- avl_ready low for 5 cycles with a write in the register -> avl_* outputs stable for 5 cycles, no wr_ack; a write with wr_data=0xDEADBEEF is accepted on the first ready cycle.
- Read accepted in the same cycle as avl_rdata_valid with rd_pend=3 -> rd_pend stays 3; rd_data_valid pulses next cycle with avl_rdata.
- avl_rdata_valid with rd_pend=0 -> err=1 and it stays set until reset. Reset during an outstanding burst -> all outputs 0 the next cycle.
